// File: rtl/branch_resolve_if.sv
// Redirect handshake between the branch resolution unit and fetch.
// The resolver is the master: it raises o_redirect_valid with a stable
// target and fetch answers with i_redirect_ready.
interface branch_resolve_if;
  logic        o_redirect_valid;
  logic        i_redirect_ready;
  logic [31:0] o_redirect_pc;

  modport master (
    output o_redirect_valid,
    output o_redirect_pc,
    input  i_redirect_ready
  );

  modport slave (
    input  o_redirect_valid,
    input  o_redirect_pc,
    output i_redirect_ready
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage control-flow resolution: picks the brc compare mode, decides
// taken/not-taken for B-type and jumps, issues a registered redirect to
// fetch, squashes wrong-path instructions for FLUSH_CYCLES cycles and keeps
// conditional-branch statistics.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_br,
  input  logic              i_ex_is_jal,
  input  logic              i_ex_is_jalr,
  input  logic [2:0]        i_ex_funct3,
  input  logic [31:0]       i_ex_pc,
  input  logic [31:0]       i_ex_imm,
  input  logic [31:0]       i_ex_rs1_data,
  input  logic              i_br_less,
  input  logic              i_br_equal,
  output logic              o_br_un,
  branch_resolve_if.master  rd,
  output logic              o_flush,
  output logic              o_stall,
  output logic              o_misalign,
  output logic [CNT_W-1:0]  o_br_cnt,
  output logic [CNT_W-1:0]  o_taken_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t           state_r, state_nx_s;
  logic [FC_W-1:0]  flush_cnt_r, flush_cnt_nx_s;
  logic [31:0]      redirect_pc_r;
  logic             redirect_valid_r;
  logic             flush_r;
  logic             stall_r;
  logic             misalign_r;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] taken_cnt_r;

  logic             cond_legal_s;
  logic             cond_taken_s;
  logic             taken_s;
  logic [31:0]      target_s;
  logic             resolve_s;
  logic             load_pc_s;
  logic             misalign_nx_s;
  logic             br_inc_s;
  logic             taken_inc_s;

  // Compare mode for brc: signed for BLT/BGE, unsigned for BLTU/BGEU
  assign o_br_un = ~i_ex_funct3[1];

  // Branch condition decode and target computation for the EX instruction
  always_comb begin
    cond_legal_s = i_ex_funct3[2] | ~i_ex_funct3[1];
    cond_taken_s = 1'b0;
    case (i_ex_funct3)
      3'b000:  cond_taken_s = i_br_equal;
      3'b001:  cond_taken_s = ~i_br_equal;
      3'b100:  cond_taken_s = i_br_less;
      3'b110:  cond_taken_s = i_br_less;
      3'b101:  cond_taken_s = ~i_br_less;
      3'b111:  cond_taken_s = ~i_br_less;
      default: cond_taken_s = 1'b0;
    endcase

    if (i_ex_is_br) begin
      taken_s  = cond_taken_s;
      target_s = i_ex_pc + i_ex_imm;
    end else if (i_ex_is_jalr) begin
      taken_s  = 1'b1;
      target_s = (i_ex_rs1_data + i_ex_imm) & 32'hFFFF_FFFE;
    end else if (i_ex_is_jal) begin
      taken_s  = 1'b1;
      target_s = i_ex_pc + i_ex_imm;
    end else begin
      taken_s  = 1'b0;
      target_s = i_ex_pc + i_ex_imm;
    end

    resolve_s     = (state_r == IDLE) & i_ex_valid;
    misalign_nx_s = resolve_s & taken_s & target_s[1];
    br_inc_s      = resolve_s & i_ex_is_br & cond_legal_s;
    taken_inc_s   = br_inc_s & cond_taken_s;
  end

  // Next-state logic: resolve in IDLE, hold the redirect in REQ, count down in FLUSH
  always_comb begin
    state_nx_s     = state_r;
    flush_cnt_nx_s = flush_cnt_r;
    load_pc_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (resolve_s && taken_s && !target_s[1]) begin
          state_nx_s = REQ;
          load_pc_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        if (rd.i_redirect_ready) begin
          state_nx_s     = FLUSH;
          flush_cnt_nx_s = FC_LOAD;
        end else begin
          state_nx_s = REQ;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == {FC_W{1'b0}}) begin
          state_nx_s = IDLE;
        end else begin
          flush_cnt_nx_s = flush_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx_s     = IDLE;
        flush_cnt_nx_s = {FC_W{1'b0}};
      end
    endcase
  end

  // FSM state, flush counter and registered handshake/squash outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r          <= IDLE;
      flush_cnt_r      <= {FC_W{1'b0}};
      redirect_valid_r <= 1'b0;
      flush_r          <= 1'b0;
      stall_r          <= 1'b0;
      misalign_r       <= 1'b0;
    end else begin
      state_r          <= state_nx_s;
      flush_cnt_r      <= flush_cnt_nx_s;
      redirect_valid_r <= (state_nx_s == REQ);
      flush_r          <= (state_nx_s == FLUSH);
      stall_r          <= (state_nx_s != IDLE);
      misalign_r       <= misalign_nx_s;
    end
  end

  // Redirect target capture; held stable for the whole REQ phase
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      redirect_pc_r <= 32'h0000_0000;
    end else if (load_pc_s) begin
      redirect_pc_r <= target_s;
    end
  end

  // Conditional-branch statistics, wrapping modulo 2^CNT_W
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      br_cnt_r    <= {CNT_W{1'b0}};
      taken_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (br_inc_s) begin
        br_cnt_r <= br_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (taken_inc_s) begin
        taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rd.o_redirect_valid = redirect_valid_r;
  assign rd.o_redirect_pc    = redirect_pc_r;
  assign o_flush             = flush_r;
  assign o_stall             = stall_r;
  assign o_misalign          = misalign_r;
  assign o_br_cnt            = br_cnt_r;
  assign o_taken_cnt         = taken_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve (FLUSH_CYCLES=2, CNT_W=4). Expected
// redirect targets go into a queue at issue time; a negedge monitor pops and
// compares on every redirect handshake and counts misalign pulses.
module tb_branch_resolve;
  logic        i_clk;
  logic        i_reset;
  logic        i_ex_valid, i_ex_is_br, i_ex_is_jal, i_ex_is_jalr;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_pc, i_ex_imm, i_ex_rs1_data;
  logic        i_br_less, i_br_equal;
  logic        o_br_un, o_flush, o_stall, o_misalign;
  logic [3:0]  o_br_cnt, o_taken_cnt;

  branch_resolve_if rd_if ();

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ex_valid   (i_ex_valid),
    .i_ex_is_br   (i_ex_is_br),
    .i_ex_is_jal  (i_ex_is_jal),
    .i_ex_is_jalr (i_ex_is_jalr),
    .i_ex_funct3  (i_ex_funct3),
    .i_ex_pc      (i_ex_pc),
    .i_ex_imm     (i_ex_imm),
    .i_ex_rs1_data(i_ex_rs1_data),
    .i_br_less    (i_br_less),
    .i_br_equal   (i_br_equal),
    .o_br_un      (o_br_un),
    .rd           (rd_if.master),
    .o_flush      (o_flush),
    .o_stall      (o_stall),
    .o_misalign   (o_misalign),
    .o_br_cnt     (o_br_cnt),
    .o_taken_cnt  (o_taken_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int mis_seen = 0;
  int mis_exp = 0;
  logic [31:0] exp_q[$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected target
  always @(negedge i_clk) begin
    if (rd_if.o_redirect_valid === 1'b1 && rd_if.i_redirect_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL redirect_unexpected: got pc 0x%0h, expected no redirect", rd_if.o_redirect_pc);
      end else begin
        check("redirect_pc", rd_if.o_redirect_pc, exp_q.pop_front());
      end
    end
    if (o_misalign === 1'b1) mis_seen++;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ex(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic less, input logic eq);
    i_ex_valid = 1'b1; i_ex_is_br = br; i_ex_is_jal = jal; i_ex_is_jalr = jalr;
    i_ex_funct3 = f3; i_ex_pc = pc; i_ex_imm = imm; i_ex_rs1_data = rs1;
    i_br_less = less; i_br_equal = eq;
  endtask

  task automatic clr_ex();
    i_ex_valid = 1'b0; i_ex_is_br = 1'b0; i_ex_is_jal = 1'b0; i_ex_is_jalr = 1'b0;
    i_ex_funct3 = 3'b000; i_br_less = 1'b0; i_br_equal = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_stall === 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, o_stall}, 32'd0);
  endtask

  initial begin
    i_reset = 1'b1;
    rd_if.i_redirect_ready = 1'b1;
    i_ex_pc = 32'd0; i_ex_imm = 32'd0; i_ex_rs1_data = 32'd0;
    clr_ex();
    #1;
    check("rst_valid", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("rst_pc", rd_if.o_redirect_pc, 32'd0);
    check("rst_flush", {31'd0, o_flush}, 32'd0);
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    check("rst_misalign", {31'd0, o_misalign}, 32'd0);
    check("rst_br_cnt", {28'd0, o_br_cnt}, 32'd0);
    check("rst_taken_cnt", {28'd0, o_taken_cnt}, 32'd0);
    step(); step();
    i_reset = 1'b0;
    step();

    // BEQ taken, ready high: full redirect/flush timeline
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'h120);
    step(); clr_ex();
    check("beq_valid_n1", {31'd0, rd_if.o_redirect_valid}, 32'd1);
    check("beq_pc_n1", rd_if.o_redirect_pc, 32'h120);
    check("beq_stall_n1", {31'd0, o_stall}, 32'd1);
    check("beq_flush_n1", {31'd0, o_flush}, 32'd0);
    check("beq_br_cnt", {28'd0, o_br_cnt}, 32'd1);
    check("beq_taken_cnt", {28'd0, o_taken_cnt}, 32'd1);
    step();
    check("beq_valid_n2", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("beq_flush_n2", {31'd0, o_flush}, 32'd1);
    check("beq_stall_n2", {31'd0, o_stall}, 32'd1);
    step();
    check("beq_flush_n3", {31'd0, o_flush}, 32'd1);
    step();
    check("beq_flush_n4", {31'd0, o_flush}, 32'd0);
    check("beq_stall_n4", {31'd0, o_stall}, 32'd0);

    // BLTU 0xFFFFFFFF vs 0: unsigned compare, not less -> not taken
    set_ex(1'b1, 1'b0, 1'b0, 3'b110, 32'h200, 32'h40, 32'd0, 1'b0, 1'b0);
    #1;
    check("bltu_br_un", {31'd0, o_br_un}, 32'd0);
    step(); clr_ex();
    check("bltu_valid", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("bltu_stall", {31'd0, o_stall}, 32'd0);
    check("bltu_br_cnt", {28'd0, o_br_cnt}, 32'd2);
    check("bltu_taken_cnt", {28'd0, o_taken_cnt}, 32'd1);

    // BLT same operands: signed compare, less -> taken to 0x240
    set_ex(1'b1, 1'b0, 1'b0, 3'b100, 32'h200, 32'h40, 32'd0, 1'b1, 1'b0);
    #1;
    check("blt_br_un", {31'd0, o_br_un}, 32'd1);
    exp_q.push_back(32'h240);
    step(); clr_ex();
    check("blt_valid", {31'd0, rd_if.o_redirect_valid}, 32'd1);
    check("blt_br_cnt", {28'd0, o_br_cnt}, 32'd3);
    check("blt_taken_cnt", {28'd0, o_taken_cnt}, 32'd2);
    wait_idle();

    // JALR 0x1003 + 0 -> 0x1002, bit 1 set: misalign pulse, no redirect
    set_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h40, 32'h0, 32'h1003, 1'b0, 1'b0);
    mis_exp++;
    step(); clr_ex();
    check("jalr_mis_pulse", {31'd0, o_misalign}, 32'd1);
    check("jalr_mis_valid", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("jalr_mis_stall", {31'd0, o_stall}, 32'd0);
    step();
    check("jalr_mis_end", {31'd0, o_misalign}, 32'd0);

    // JALR 0x1001 + 0 -> 0x1000, redirect; jumps leave counters alone
    set_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h40, 32'h0, 32'h1001, 1'b0, 1'b0);
    exp_q.push_back(32'h1000);
    step(); clr_ex();
    check("jalr_valid", {31'd0, rd_if.o_redirect_valid}, 32'd1);
    check("jalr_pc", rd_if.o_redirect_pc, 32'h1000);
    wait_idle();
    check("jalr_br_cnt", {28'd0, o_br_cnt}, 32'd3);
    check("jalr_taken_cnt", {28'd0, o_taken_cnt}, 32'd2);

    // Backpressure: ready low 3 cycles, wrong-path branches held on EX
    rd_if.i_redirect_ready = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'h120);
    step();
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h500, 32'h8, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, rd_if.o_redirect_valid}, 32'd1);
      check("bp_pc", rd_if.o_redirect_pc, 32'h120);
      check("bp_stall", {31'd0, o_stall}, 32'd1);
      step();
    end
    rd_if.i_redirect_ready = 1'b1;
    clr_ex();
    check("bp_valid_4", {31'd0, rd_if.o_redirect_valid}, 32'd1);
    check("bp_pc_4", rd_if.o_redirect_pc, 32'h120);
    step();
    check("bp_flush", {31'd0, o_flush}, 32'd1);
    wait_idle();
    check("bp_br_cnt", {28'd0, o_br_cnt}, 32'd4);
    check("bp_taken_cnt", {28'd0, o_taken_cnt}, 32'd3);

    // Illegal funct3 010: not counted, no redirect; BNE with equal: not taken
    set_ex(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h20, 32'd0, 1'b1, 1'b1);
    step(); clr_ex();
    check("ill_valid", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("ill_br_cnt", {28'd0, o_br_cnt}, 32'd4);
    set_ex(1'b1, 1'b0, 1'b0, 3'b001, 32'h100, 32'h20, 32'd0, 1'b0, 1'b1);
    step(); clr_ex();
    check("bne_valid", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("bne_br_cnt", {28'd0, o_br_cnt}, 32'd5);
    check("bne_taken_cnt", {28'd0, o_taken_cnt}, 32'd3);

    // JAL 0x80 + 0x100 -> 0x180
    set_ex(1'b0, 1'b1, 1'b0, 3'b000, 32'h80, 32'h100, 32'd0, 1'b0, 1'b0);
    exp_q.push_back(32'h180);
    step(); clr_ex();
    check("jal_pc", rd_if.o_redirect_pc, 32'h180);
    wait_idle();
    check("jal_br_cnt", {28'd0, o_br_cnt}, 32'd5);

    // Counter wrap: 15 taken misaligned BEQs from reset, 16th wraps to 0
    i_reset = 1'b1;
    #1;
    check("wrap_rst_taken", {28'd0, o_taken_cnt}, 32'd0);
    step();
    i_reset = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h2, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step();
      mis_exp++;
    end
    check("wrap_taken_15", {28'd0, o_taken_cnt}, 32'd15);
    check("wrap_br_15", {28'd0, o_br_cnt}, 32'd15);
    step();
    mis_exp++;
    clr_ex();
    check("wrap_taken_16", {28'd0, o_taken_cnt}, 32'd0);
    check("wrap_br_16", {28'd0, o_br_cnt}, 32'd0);
    check("wrap_no_redirect", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    step();

    // Reset pulse mid-REQ: outputs drop without a clock edge
    rd_if.i_redirect_ready = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd0, 1'b0, 1'b1);
    step(); clr_ex();
    check("rreq_valid", {31'd0, rd_if.o_redirect_valid}, 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    check("rreq_valid_drop", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    check("rreq_stall_drop", {31'd0, o_stall}, 32'd0);
    check("rreq_flush_drop", {31'd0, o_flush}, 32'd0);
    check("rreq_pc_drop", rd_if.o_redirect_pc, 32'd0);
    i_reset = 1'b0;
    rd_if.i_redirect_ready = 1'b1;
    step();
    check("rreq_idle_valid", {31'd0, rd_if.o_redirect_valid}, 32'd0);
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h300, 32'h10, 32'd0, 1'b0, 1'b1);
    exp_q.push_back(32'h310);
    step(); clr_ex();
    check("rreq_next_valid", {31'd0, rd_if.o_redirect_valid}, 32'd1);
    check("rreq_next_pc", rd_if.o_redirect_pc, 32'h310);
    check("rreq_next_br_cnt", {28'd0, o_br_cnt}, 32'd1);
    check("rreq_next_taken_cnt", {28'd0, o_taken_cnt}, 32'd1);
    wait_idle();
    step();

    check("sb_pending", exp_q.size(), 32'd0);
    check("misalign_pulses", mis_seen, mis_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Control-flow resolution unit for the RV32I core, sitting at the EX-stage output of `brc`. It drives `brc`'s compare-mode select and turns `br_less`/`br_equal` into a taken/not-taken decision for B-type instructions, and into an always-taken decision for JAL/JALR. On a taken decision it computes the target and issues a registered redirect to fetch over a valid/ready handshake. After the handshake it squashes wrong-path instructions for a fixed number of cycles and keeps branch statistics counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles `o_flush` stays high after a redirect handshake (≥1)
- CNT_W, 32, width of the statistics counters

Ports:
- i_clk  in  1  core clock, all state on rising edge
- i_reset  in  1  reset, asynchronous and active-high
- i_ex_valid  in  1  EX holds a valid instruction
- i_ex_is_br  in  1  instruction is B-type
- i_ex_is_jal  in  1  instruction is JAL
- i_ex_is_jalr  in  1  instruction is JALR
- i_ex_funct3  in  3  B-type funct3
- i_ex_pc  in  32  PC of EX instruction
- i_ex_imm  in  32  sign-extended immediate
- i_ex_rs1_data  in  32  rs1 value (JALR base)
- i_br_less  in  1  from `brc`
- i_br_equal  in  1  from `brc`
- o_br_un  out  1  to `brc`: 1 = signed compare, 0 = unsigned compare
- o_redirect_valid  out  1  redirect request to fetch
- i_redirect_ready  in  1  fetch accepts redirect
- o_redirect_pc  out  32  redirect target, stable while valid
- o_flush  out  1  squash IF/ID
- o_stall  out  1  hold upstream stages
- o_misalign  out  1  one-cycle pulse: taken target with bit 1 set
- o_br_cnt  out  CNT_W  resolved conditional branches
- o_taken_cnt  out  CNT_W  taken conditional branches

## Operation
- FSM states: IDLE, REQ, FLUSH.
- `o_br_un` is combinational: `~i_ex_funct3[1]`. BLT/BGE → 1; BLTU/BGEU → 0; the value is don't-care for BEQ/BNE.
- Taken decision, evaluated in IDLE only:
  - 000 BEQ = equal
  - 001 BNE = !equal
  - 100/110 = less
  - 101/111 = !less
  - 010/011 = not taken, not counted
  - JAL/JALR = always taken
- Target computation:
  - B-type and JAL: `i_ex_pc + i_ex_imm`
  - JALR: `(i_ex_rs1_data + i_ex_imm) & ~1`
  - Additions are 32-bit modulo 2^32.
- IDLE, `i_ex_valid` with a taken decision:
  - If target[1] = 0: register target into `o_redirect_pc`, go to REQ.
  - If target[1] = 1: pulse `o_misalign` next cycle, no redirect, stay in IDLE.
- IDLE, not taken: no state change.
- REQ:
  - `o_redirect_valid` = 1 and `o_stall` = 1.
  - `o_redirect_pc` holds until the cycle in which valid & ready, then go to FLUSH.
  - `i_ex_*` inputs are ignored (wrong path).
- FLUSH:
  - `o_flush` = 1 and `o_stall` = 1 for exactly FLUSH_CYCLES cycles (down-counter), then go to IDLE.
  - `i_ex_*` inputs are ignored.
- Counters, IDLE only:
  - `o_br_cnt` increments on each valid B-type instruction with a legal funct3.
  - `o_taken_cnt` increments on each taken one, including misaligned-target branches.
  - Counters wrap modulo 2^CNT_W; jumps are not counted.

## Timing
- Reset values: state IDLE; `o_redirect_valid` 0, `o_redirect_pc` 0, `o_flush` 0, `o_stall` 0, `o_misalign` 0, counters 0.
- Reset asserted in REQ or FLUSH drops all outputs immediately (asynchronous); the pending redirect is lost.
- Branch resolved in cycle N:
  - `o_redirect_valid` rises in N+1.
  - With ready already high, the handshake completes in N+1.
  - `o_flush` is high in N+2 .. N+1+FLUSH_CYCLES.
  - IDLE accepts a new instruction in N+2+FLUSH_CYCLES.
- A cycle without ready adds exactly one cycle in REQ; valid never drops without a handshake.
- Ready while not valid has no effect.
- `o_br_un` has zero latency, so `brc` outputs are valid in the same cycle.
- Counters update on the edge ending the resolve cycle.
- `o_misalign` is registered and appears in N+1.

## Test plan
- BEQ with rs1 = rs2 = 5 (equal=1), pc = 0x100, imm = 0x20, ready high → redirect_valid in N+1 with pc 0x120; flush high 2 cycles; br_cnt = 1, taken_cnt = 1.
- BLTU with rs1 = 0xFFFFFFFF, rs2 = 0 → o_br_un = 0, brc less = 0 → not taken, no redirect; br_cnt increments, taken_cnt unchanged. BLT with the same operands → o_br_un = 1, less = 1, taken.
- JALR with rs1 = 0x1003, imm = 0 → target 0x1002 has bit 1 set → misalign pulse, no redirect. With rs1 = 0x1001 → target 0x1000, redirect issued; counters unchanged in both cases.
- Redirect backpressure: ready held low 3 cycles → valid and pc 0x120 stable for 4 cycles, stall high throughout; i_ex_valid branches during REQ ignored.
- Wrap: preload 2^CNT_W−1 taken branches (CNT_W = 4 build, 15 branches) → the 16th branch reads taken_cnt = 0.
- Reset pulse in the middle of REQ → valid, flush and stall drop without a clock edge; FSM in IDLE; next branch resolves normally.
